serial_subtractor_ctrl: RTL

//   Bit-serial subtract controller: sequences a single 1-bit subtractor cell
//   (diff = x^y^bin, bout = ~x&y | ~(x^y)&bin) over WIDTH cycles to compute A-B.

---
 rtl/serial_subtractor_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial A-B controller over one 1-bit subtractor cell
// Optional feature macro: SERSUB_SIGNED_OVF_EN (adds the two's-complement overflow output ovf)
module serial_subtractor_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERSUB_SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic x, y, cell_diff, cell_bout;

    // The 1-bit subtractor cell always looks at the LSBs of the operand shifters.
    assign x         = a_sh_q[0];
    assign y         = b_sh_q[0];
    assign cell_diff = x ^ y ^ borrow_q;
    assign cell_bout = (~x & y) | (~(x ^ y) & borrow_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERSUB_SIGNED_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    acc_d    = '0;
                    borrow_d = 1'b0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                acc_d    = {cell_diff, acc_q[WIDTH-1:1]};
                borrow_d = cell_bout;
                if (cnt_q == LAST) begin
                    // Last bit: x/y are the operand MSBs, so the sign check happens here.
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = {cell_diff, acc_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
`ifdef SERSUB_SIGNED_OVF_EN
                    ovf_d   = (x != y) && (cell_diff != x);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SERSUB_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif
endmodule
